// File: rtl/axis_write_data_pkg.sv
// Shared definitions for the AXI write-side engines.
//   state_e     : one-hot FSM states (RESET, CONFIG, SET, ACTIVE, FLUSH), shared with
//                 the write-address engine so both walk the same transfer sequence.
//   strb_width  : byte-strobe width for a given data width.
package axis_write_data_pkg;

  typedef enum logic [4:0] {
    ST_RESET  = 5'b00001,
    ST_CONFIG = 5'b00010,
    ST_SET    = 5'b00100,
    ST_ACTIVE = 5'b01000,
    ST_FLUSH  = 5'b10000
  } state_e;

  function automatic int unsigned strb_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/axis_write_data_deserializer.sv
// Packs DATA_NB narrow words into one wide beat, first word in the LSB lane.
//   clr_i        : drop any partially filled beat and restart at lane 0
//   flush_i      : emit the partially filled beat (unfilled lanes zeroed, strobes low)
//   up_*         : narrow stream in (valid/ready)
//   down_data_o  : packed beat, down_strb_o marks filled lanes
//   down_valid_o : beat complete (last lane accepted) or flushed this cycle
//   down_ready_i : downstream can take a beat; gates up_ready_o
module axis_deserializer
  import axis_write_data_pkg::*;
#(
  parameter int unsigned DATA_NB    = 2,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  clr_i,
  input  logic                                  flush_i,
  input  logic [DATA_WIDTH-1:0]                 up_data_i,
  input  logic                                  up_valid_i,
  output logic                                  up_ready_o,
  output logic [DATA_NB*DATA_WIDTH-1:0]         down_data_o,
  output logic [strb_width(DATA_NB*DATA_WIDTH)-1:0] down_strb_o,
  output logic                                  down_valid_o,
  input  logic                                  down_ready_i
);

  localparam int unsigned LW         = (DATA_NB > 1) ? $clog2(DATA_NB) : 1;
  localparam int unsigned LANE_BYTES = strb_width(DATA_WIDTH);

  logic [DATA_NB-1:0][DATA_WIDTH-1:0] word_q;
  logic [LW-1:0]                      lane_q;
  logic                               accept;
  logic                               last_lane;

  assign up_ready_o   = down_ready_i;
  assign accept       = up_valid_i & up_ready_o;
  assign last_lane    = (lane_q == LW'(DATA_NB - 1));
  assign down_valid_o = (accept & last_lane) | (flush_i & (lane_q != '0));

  // The word arriving in the last lane is forwarded directly so a full beat is
  // emitted in the same cycle the word is accepted.
  always_comb begin
    down_data_o = '0;
    down_strb_o = '0;
    for (int unsigned i = 0; i < DATA_NB; i++) begin
      if (LW'(i) < lane_q) begin
        down_data_o[i*DATA_WIDTH +: DATA_WIDTH] = word_q[i];
        down_strb_o[i*LANE_BYTES +: LANE_BYTES] = '1;
      end else if ((LW'(i) == lane_q) && accept) begin
        down_data_o[i*DATA_WIDTH +: DATA_WIDTH] = up_data_i;
        down_strb_o[i*LANE_BYTES +: LANE_BYTES] = '1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_i || flush_i) begin
      lane_q <= '0;
    end else if (accept) begin
      lane_q <= last_lane ? '0 : lane_q + LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) word_q[lane_q] <= up_data_i;
  end

endmodule

// File: rtl/fifo_simple.sv
// Simple synchronous FIFO with first-word-fall-through read port.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   wr_en_i    : push wr_data_i (ignored when full)
//   rd_en_i    : pop head entry (ignored when empty)
//   rd_data_o  : head entry, valid whenever empty_o is low
//   empty_o    : no entries
//   afull_o    : at least DEPTH-AFULL_MARGIN entries (margin 0 gives a plain full flag)
module fifo_simple #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned AFULL_MARGIN = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  empty_o,
  output logic                  afull_o
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q;
  logic [ADDR_WIDTH-1:0] rd_ptr_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  full;
  logic                  wr_ok;
  logic                  rd_ok;

  assign full      = (count_q == (ADDR_WIDTH+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign afull_o   = (count_q >= (ADDR_WIDTH+1)'(DEPTH - AFULL_MARGIN));
  assign wr_ok     = wr_en_i & ~full;
  assign rd_ok     = rd_en_i & ~empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/axis_write_data.sv
// Write-side AXI data-channel engine.
//   clk, rst            : clock, synchronous active-high reset
//   cfg_length/val/rdy  : per-transfer length (stream words) into the config FIFO
//   data/valid/ready    : narrow input stream
//   axi_wdata/wstrb/wlast/wvalid/wready : AXI W channel
// Words are packed WIDTH_RATIO per beat, buffered as {wlast,wstrb,wdata} and drained
// through an output register. wlast marks every BURST_LEN-th beat and the final beat
// of each transfer, matching the address engine's burst split.
module axis_write_data
  import axis_write_data_pkg::*;
#(
  parameter int unsigned BUF_CFG_AWIDTH = 5,
  parameter int unsigned BUF_AWIDTH     = 9,
  parameter int unsigned CFG_DWIDTH     = 32,
  parameter int unsigned WIDTH_RATIO    = 2,
  parameter int unsigned BURST_LEN      = 16,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned DATA_WIDTH     = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [CFG_DWIDTH-1:0]                 cfg_length,
  input  logic                                  cfg_val,
  output logic                                  cfg_rdy,
  input  logic [DATA_WIDTH-1:0]                 data,
  input  logic                                  valid,
  output logic                                  ready,
  output logic [AXI_DATA_WIDTH-1:0]             axi_wdata,
  output logic [strb_width(AXI_DATA_WIDTH)-1:0] axi_wstrb,
  output logic                                  axi_wlast,
  output logic                                  axi_wvalid,
  input  logic                                  axi_wready
);

  localparam int unsigned STRB_W  = strb_width(AXI_DATA_WIDTH);
  localparam int unsigned BUF_W   = 1 + STRB_W + AXI_DATA_WIDTH;
  localparam int unsigned BURST_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  state_e state_q, state_d;

  logic [CFG_DWIDTH-1:0] cfg_head;
  logic                  cfg_empty;
  logic                  cfg_full;
  logic                  cfg_pop;
  logic [CFG_DWIDTH-1:0] cfg_len_q;
  logic [CFG_DWIDTH-1:0] len_m1_q;
  logic [CFG_DWIDTH-1:0] str_cnt_q;
  logic [BURST_W-1:0]    burst_cnt_q;

  logic                  st_active;
  logic                  cnt_ok;
  logic                  last_word;
  logic                  des_ready;
  logic                  word_acc;
  logic                  des_valid;
  logic [AXI_DATA_WIDTH-1:0] des_data;
  logic [STRB_W-1:0]     des_strb;
  logic                  wlast_push;

  logic [BUF_W-1:0]      buf_dout;
  logic                  buf_empty;
  logic                  buf_afull;
  logic                  buf_rd;

  logic [AXI_DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic                  wlast_q;
  logic                  wvalid_q;

  // Config FIFO (margin 0: afull is the plain full flag).
  fifo_simple #(
    .DATA_WIDTH  (CFG_DWIDTH),
    .ADDR_WIDTH  (BUF_CFG_AWIDTH),
    .AFULL_MARGIN(0)
  ) u_cfg_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en_i  (cfg_val),
    .wr_data_i(cfg_length),
    .rd_en_i  (cfg_pop),
    .rd_data_o(cfg_head),
    .empty_o  (cfg_empty),
    .afull_o  (cfg_full)
  );

  assign cfg_rdy = ~cfg_full;
  assign cfg_pop = (state_q == ST_CONFIG) & ~cfg_empty;

  assign st_active = (state_q == ST_ACTIVE);
  assign cnt_ok    = (str_cnt_q <= len_m1_q);
  assign last_word = (str_cnt_q == len_m1_q);
  assign ready     = st_active & cnt_ok & des_ready;
  assign word_acc  = valid & ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RESET;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RESET:  state_d = ST_CONFIG;
      ST_CONFIG: if (!cfg_empty) state_d = ST_SET;
      ST_SET:    state_d = (cfg_len_q == '0) ? ST_CONFIG : ST_ACTIVE;
      ST_ACTIVE: if (word_acc && last_word) state_d = des_valid ? ST_CONFIG : ST_FLUSH;
      ST_FLUSH:  state_d = ST_CONFIG;
      default:   state_d = ST_RESET;
    endcase
  end

  // A beat pushed from FLUSH, or one completed by the last word, ends the transfer.
  assign wlast_push = (burst_cnt_q == BURST_W'(BURST_LEN - 1)) |
                      (state_q == ST_FLUSH) | (word_acc & last_word);

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_len_q   <= '0;
      len_m1_q    <= '0;
      str_cnt_q   <= '0;
      burst_cnt_q <= '0;
    end else begin
      if (cfg_pop) cfg_len_q <= cfg_head;
      if (state_q == ST_SET) begin
        len_m1_q    <= cfg_len_q - 1'b1;
        str_cnt_q   <= '0;
        burst_cnt_q <= '0;
      end else begin
        if (word_acc)  str_cnt_q   <= str_cnt_q + 1'b1;
        if (des_valid) burst_cnt_q <= wlast_push ? '0 : burst_cnt_q + 1'b1;
      end
    end
  end

  axis_deserializer #(
    .DATA_NB   (WIDTH_RATIO),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_deser (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (state_q == ST_SET),
    .flush_i     (state_q == ST_FLUSH),
    .up_data_i   (data),
    .up_valid_i  (valid & st_active & cnt_ok),
    .up_ready_o  (des_ready),
    .down_data_o (des_data),
    .down_strb_o (des_strb),
    .down_valid_o(des_valid),
    .down_ready_i(~buf_afull)
  );

  // Margin leaves room for the beat in flight plus a trailing flush beat.
  fifo_simple #(
    .DATA_WIDTH  (BUF_W),
    .ADDR_WIDTH  (BUF_AWIDTH),
    .AFULL_MARGIN(4)
  ) u_buf_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en_i  (des_valid),
    .wr_data_i({wlast_push, des_strb, des_data}),
    .rd_en_i  (buf_rd),
    .rd_data_o(buf_dout),
    .empty_o  (buf_empty),
    .afull_o  (buf_afull)
  );

  // Reload on the handshake cycle itself so back-to-back beats have no bubble.
  assign buf_rd = ~buf_empty & (~wvalid_q | axi_wready);

  always_ff @(posedge clk) begin
    if (rst) begin
      wdata_q  <= '0;
      wstrb_q  <= '0;
      wlast_q  <= 1'b0;
      wvalid_q <= 1'b0;
    end else if (buf_rd) begin
      {wlast_q, wstrb_q, wdata_q} <= buf_dout;
      wvalid_q <= 1'b1;
    end else if (axi_wready) begin
      wvalid_q <= 1'b0;
    end
  end

  assign axi_wdata  = wdata_q;
  assign axi_wstrb  = wstrb_q;
  assign axi_wlast  = wlast_q;
  assign axi_wvalid = wvalid_q;

endmodule
